// File: rtl/avalon_timer_pkg.sv
// Shared register map and bit positions for the Avalon multi-channel timer bank.
package avalon_timer_pkg;
  // Register offsets within one channel's 8-word window
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  // Number of writable offsets; the reserved word gets no strobe
  localparam int NUM_WR = 7;

  // CONTROL bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // STATUS bit positions
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: config registers, prescaler, down counter, RUN/TO and read mux.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int          COUNT_W        = 32,
  parameter int          PRESC_W        = 8,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_WR-1:0] wr_stb,
  input  logic [15:0]       wdata,
  input  logic [2:0]        offset,
  output logic [15:0]       rdata,
  output logic              irq
);

  logic               ito, cont, run, to, force_reload;
  logic [COUNT_W-1:0] period, period_wr, count, snap;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [31:0]        period_ext, snap_ext;
  logic               tick, zero, timeout, start, stop, per_wr;

  assign start      = wr_stb[REG_CONTROL] & wdata[CTRL_START];
  assign stop       = wr_stb[REG_CONTROL] & wdata[CTRL_STOP];
  assign tick       = run & (pcnt == '0);
  assign zero       = (count == '0);
  // A pending forced reload pre-empts any timeout in the same cycle
  assign timeout    = tick & zero & ~force_reload;
  assign period_ext = 32'(period);
  assign snap_ext   = 32'(snap);
  // With a 16-bit counter there is no high half, so PERIOD_H writes are inert
  assign per_wr     = wr_stb[REG_PERIOD_L] | (wr_stb[REG_PERIOD_H] & (COUNT_W > 16));
  assign irq        = to & ito;

  // Merge PERIOD_L / PERIOD_H writes into the stored period
  always_comb begin
    period_wr = period;
    if (wr_stb[REG_PERIOD_L]) period_wr = COUNT_W'({period_ext[31:16], wdata});
    if (wr_stb[REG_PERIOD_H] && COUNT_W > 16) period_wr = COUNT_W'({wdata, period_wr[15:0]});
  end

  // Software-visible configuration and snapshot registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ito          <= 1'b0;
      cont         <= 1'b0;
      presc        <= '0;
      period       <= COUNT_W'(DEFAULT_PERIOD);
      snap         <= '0;
      force_reload <= 1'b0;
    end else begin
      if (wr_stb[REG_CONTROL]) begin
        ito  <= wdata[CTRL_ITO];
        cont <= wdata[CTRL_CONT];
      end
      if (wr_stb[REG_PRESCALE]) presc <= wdata[PRESC_W-1:0];
      period <= period_wr;
      // Snapshot takes the counter value before this cycle's decrement
      if (wr_stb[REG_SNAP_L] | wr_stb[REG_SNAP_H]) snap <= count;
      force_reload <= per_wr;
    end
  end

  // RUN and TO flags; reload beats START, START beats STOP, status clear beats timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b0;
      to  <= 1'b0;
    end else begin
      if (force_reload)          run <= 1'b0;
      else if (start)            run <= 1'b1;
      else if (stop)             run <= 1'b0;
      else if (timeout && !cont) run <= 1'b0;

      if (wr_stb[REG_STATUS]) to <= 1'b0;
      else if (timeout)       to <= 1'b1;
    end
  end

  // Prescaler and down counter; prescaler idles at PRESCALE while stopped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= COUNT_W'(DEFAULT_PERIOD);
      pcnt  <= '0;
    end else begin
      if (force_reload) count <= period;
      else if (tick)    count <= zero ? period : count - COUNT_W'(1);

      if (!run || force_reload || tick) pcnt <= presc;
      else                              pcnt <= pcnt - PRESC_W'(1);
    end
  end

  // Per-channel read mux
  always_comb begin
    rdata = '0;
    case (offset)
      REG_STATUS: begin
        rdata[ST_TO]  = to;
        rdata[ST_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTRL_ITO]  = ito;
        rdata[CTRL_CONT] = cont;
      end
      REG_PERIOD_L: rdata = period_ext[15:0];
      REG_PERIOD_H: rdata = period_ext[31:16];
      REG_SNAP_L:   rdata = snap_ext[15:0];
      REG_SNAP_H:   rdata = snap_ext[31:16];
      REG_PRESCALE: rdata = 16'(presc);
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM bank of NUM_CH independent interval timers with combined interrupt.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter  int          NUM_CH         = 2,
  parameter  int          COUNT_W        = 32,
  parameter  int          PRESC_W        = 8,
  parameter  int unsigned DEFAULT_PERIOD = 49999,
  localparam int          ADDR_W         = 3 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  logic [31:0]             ch_idx;
  logic [2:0]              offset;
  logic                    wr_en;
  logic [NUM_WR-1:0]       off_dec;
  logic [NUM_CH-1:0][15:0] ch_rdata;
  logic [NUM_CH-1:0]       ch_irq;
  logic [15:0]             rd_mux;

  // Upper address bits select the channel; a 1-channel bank has none
  assign ch_idx = 32'(address >> 3);
  assign offset = address[2:0];
  assign wr_en  = chipselect & ~write_n;

  // One-hot offset decode, reserved word excluded
  always_comb begin
    off_dec = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (offset == 3'(j)) off_dec[j] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [NUM_WR-1:0] stb;
    assign stb = (wr_en && ch_idx == 32'(i)) ? off_dec : '0;

    timer_channel #(
      .COUNT_W        (COUNT_W),
      .PRESC_W        (PRESC_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_stb  (stb),
      .wdata   (writedata),
      .offset  (offset),
      .rdata   (ch_rdata[i]),
      .irq     (ch_irq[i])
    );
  end

  // Channel select for reads; unmapped channel indices read 0
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_idx == 32'(i)) rd_mux = ch_rdata[i];
  end

  // Read data is registered every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq_vec = ch_irq;
  assign irq     = |ch_irq;

endmodule
